// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operation sequencer and the branch unit.
// State encoding, condition codes and flag bit positions live here so both agree.
package alu_seq_pkg;

    localparam int FUNSEL_W = 5;
    localparam int COND_W   = 3;
    localparam int FLAG_W   = 4;

    // Flags bus ordering is {Z, C, N, O}
    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_O = 0;

    localparam logic [COND_W-1:0] COND_AL = 3'd0;
    localparam logic [COND_W-1:0] COND_Z  = 3'd1;
    localparam logic [COND_W-1:0] COND_NZ = 3'd2;
    localparam logic [COND_W-1:0] COND_C  = 3'd3;
    localparam logic [COND_W-1:0] COND_NC = 3'd4;
    localparam logic [COND_W-1:0] COND_N  = 3'd5;
    localparam logic [COND_W-1:0] COND_O  = 3'd6;
    localparam logic [COND_W-1:0] COND_NV = 3'd7;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        FLAGWAIT = 2'd2,
        RESP     = 2'd3
    } seq_state_t;

endpackage

// File: rtl/alu_cond_eval.sv
// Combinational branch-condition evaluator on the {Z, C, N, O} flags bus.
// Also instantiated by the branch unit.
module alu_cond_eval
    import alu_seq_pkg::*;
(
    input  logic [FLAG_W-1:0] flags,
    input  logic [COND_W-1:0] cond,
    output logic              cond_true
);

    always_comb begin
        cond_true = 1'b0;
        case (cond)
            COND_AL: cond_true = 1'b1;
            COND_Z:  cond_true = flags[FLAG_Z];
            COND_NZ: cond_true = ~flags[FLAG_Z];
            COND_C:  cond_true = flags[FLAG_C];
            COND_NC: cond_true = ~flags[FLAG_C];
            COND_N:  cond_true = flags[FLAG_N];
            COND_O:  cond_true = flags[FLAG_O];
            COND_NV: cond_true = 1'b0;
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issues one ALU op per request, captures ALUOut and post-op flags, returns them with a condition result.
// Optional macro ALU_SEQ_FAST_PATH_EN: ops that do not write flags skip FLAGWAIT.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FLAG_WIDTH = 4
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  ReqValid,
    output logic                  ReqReady,
    input  logic [FUNSEL_W-1:0]   ReqFunSel,
    input  logic                  ReqSetFlags,
    input  logic [COND_W-1:0]     ReqCond,
    output logic [FUNSEL_W-1:0]   FunSel,
    output logic                  WF,
    input  logic [DATA_WIDTH-1:0] ALUOut,
    input  logic [FLAG_WIDTH-1:0] FlagsIn,
    output logic                  RspValid,
    input  logic                  RspReady,
    output logic [DATA_WIDTH-1:0] RspData,
    output logic [FLAG_WIDTH-1:0] RspFlags,
    output logic                  RspCondTrue
);

    seq_state_t          state;
    seq_state_t          state_next;
    logic [FUNSEL_W-1:0] op_funsel;
    logic                op_setflags;
    logic [COND_W-1:0]   op_cond;
    logic                accept;
    logic                capture_flags;
    logic                cond_true;

    // Flags are evaluated straight off the ALU bus; they are only sampled when capture_flags is high
    alu_cond_eval u_cond_eval (
        .flags     (FlagsIn),
        .cond      (op_cond),
        .cond_true (cond_true)
    );

    assign FunSel = op_funsel;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state       <= IDLE;
            op_funsel   <= '0;
            op_setflags <= 1'b0;
            op_cond     <= '0;
            RspData     <= '0;
            RspFlags    <= '0;
            RspCondTrue <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                op_funsel   <= ReqFunSel;
                op_setflags <= ReqSetFlags;
                op_cond     <= ReqCond;
            end
            if (state == ISSUE) begin
                RspData <= ALUOut;
            end
            if (capture_flags) begin
                RspFlags    <= FlagsIn;
                RspCondTrue <= cond_true;
            end
        end
    end

    always_comb begin
        state_next    = state;
        ReqReady      = 1'b0;
        WF            = 1'b0;
        RspValid      = 1'b0;
        accept        = 1'b0;
        capture_flags = 1'b0;
        case (state)
            IDLE: begin
                ReqReady = 1'b1;
                if (ReqValid) begin
                    accept     = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                WF = op_setflags;
`ifdef ALU_SEQ_FAST_PATH_EN
                // Without a flag write the ALU flags are already settled, so sample them now
                if (!op_setflags) begin
                    capture_flags = 1'b1;
                    state_next    = RESP;
                end else begin
                    state_next = FLAGWAIT;
                end
`else
                state_next = FLAGWAIT;
`endif
            end
            FLAGWAIT: begin
                capture_flags = 1'b1;
                state_next    = RESP;
            end
            RESP: begin
                RspValid = 1'b1;
                if (RspReady) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
